// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline inter-stage registers.
// Contents: the nop encoding, the default reset PC, the occupancy
// encodings, and a helper that turns slot valid bits into an occupancy.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Occupancy from the output-slot and skid-slot valid bits. The skid
  // slot only fills while the output slot is full, so {0,1} never occurs.
  function automatic occ_e occ_of(input logic out_valid, input logic skid_valid);
    occ_e occ;
    case ({out_valid, skid_valid})
      2'b10:   occ = OCC_ONE;
      2'b11:   occ = OCC_TWO;
      default: occ = OCC_EMPTY;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline inter-stage register.
// Upstream side:   in_valid, in_ready, in_pc, in_instr, in_data
// Downstream side: out_valid, out_ready, out_pc, out_instr, out_data
// Status:          occupancy (entries held, 0..2)
// master = the surrounding pipeline / testbench, slave = the stage register.
interface pipe_stage_reg_if #(
  parameter int DW = 32
);
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   in_pc;
  logic [31:0]   in_instr;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_instr;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;

  modport master (
    output in_valid, in_pc, in_instr, in_data, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_data, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_data, occupancy
  );
endinterface

// File: rtl/pipe_slot.sv
// One pipeline entry: valid + PC + instruction + payload register.
// Ports: clk, reset (sync, active-high); i_load writes i_pc/i_instr/i_data
// and sets valid; i_clear drops valid and turns the entry into a bubble
// (instr/data zeroed, PC kept for EPC use). i_clear wins over i_load.
// Outputs o_valid/o_pc/o_instr/o_data are the registered contents.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_load,
  input  logic          i_clear,
  input  logic [31:0]   i_pc,
  input  logic [31:0]   i_instr,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  output logic [31:0]   o_pc,
  output logic [31:0]   o_instr,
  output logic [DW-1:0] o_data
);

  logic          r_valid;
  logic [31:0]   r_pc;
  logic [31:0]   r_instr;
  logic [DW-1:0] r_data;

  // NOTE: non-blocking assignments so every flop samples pre-edge values;
  // the payload is reset too because bubble contents are visible downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
      r_data  <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
      r_instr <= NOP_INSTR;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_instr <= i_instr;
      r_data  <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_data  = r_data;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic inter-stage register (F/D, D/E, E/M, M/W) with valid/ready
// handshake, optional 2-entry skid buffer and bubble-injecting flush.
// Ports: clk, reset (sync, active-high), flush (drop all entries, keep
// out_pc), bus (slave side of pipe_stage_reg_if: in_*, out_*, occupancy).
// SKID=1: in_ready comes straight from the skid valid flop.
// SKID=0: single register, in_ready = out_ready || !out_valid.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          DW       = 32,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter bit          SKID     = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  pipe_stage_reg_if.slave         bus
);

  logic          w_accept;
  logic          w_emit;
  logic          w_out_valid;
  logic          w_out_load;
  logic          w_out_clear;
  logic          w_out_sel_skid;
  logic          w_skid_load;
  logic          w_skid_clear;
  logic          w_skid_valid;
  logic [31:0]   w_skid_pc;
  logic [31:0]   w_skid_instr;
  logic [DW-1:0] w_skid_data;

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_emit   = w_out_valid && bus.out_ready;

  // The output slot always holds the oldest entry; the skid slot only
  // fills when the output slot is full and stalled, so order is preserved.
  // NOTE: every signal gets a default first so no path infers a latch.
  always_comb begin
    w_out_load     = 1'b0;
    w_out_clear    = 1'b0;
    w_out_sel_skid = 1'b0;
    w_skid_load    = 1'b0;
    w_skid_clear   = 1'b0;
    if (flush) begin
      // Any input presented this cycle is dropped along with held entries.
      w_out_clear  = 1'b1;
      w_skid_clear = 1'b1;
    end else if (w_emit && w_skid_valid) begin
      // TWO -> ONE: skid entry advances; no accept possible while full.
      w_out_load     = 1'b1;
      w_out_sel_skid = 1'b1;
      w_skid_clear   = 1'b1;
    end else if (w_accept && (!w_out_valid || w_emit)) begin
      w_out_load = 1'b1;
    end else if (w_accept) begin
      w_skid_load = 1'b1;
    end else if (w_emit) begin
      w_out_clear = 1'b1;
    end
  end

  pipe_slot #(.DW(DW), .RESET_PC(RESET_PC)) u_out_slot (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_out_load),
    .i_clear (w_out_clear),
    .i_pc    (w_out_sel_skid ? w_skid_pc    : bus.in_pc),
    .i_instr (w_out_sel_skid ? w_skid_instr : bus.in_instr),
    .i_data  (w_out_sel_skid ? w_skid_data  : bus.in_data),
    .o_valid (w_out_valid),
    .o_pc    (bus.out_pc),
    .o_instr (bus.out_instr),
    .o_data  (bus.out_data)
  );

  generate
    if (SKID) begin : g_skid
      pipe_slot #(.DW(DW), .RESET_PC(RESET_PC)) u_skid_slot (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_skid_load),
        .i_clear (w_skid_clear),
        .i_pc    (bus.in_pc),
        .i_instr (bus.in_instr),
        .i_data  (bus.in_data),
        .o_valid (w_skid_valid),
        .o_pc    (w_skid_pc),
        .o_instr (w_skid_instr),
        .o_data  (w_skid_data)
      );
      // Registered ready: never combinationally depends on out_ready.
      assign bus.in_ready = !w_skid_valid;
    end else begin : g_no_skid
      logic w_unused_skid_ctl;
      assign w_unused_skid_ctl = w_skid_load | w_skid_clear;
      assign w_skid_valid      = 1'b0;
      assign w_skid_pc         = RESET_PC;
      assign w_skid_instr      = NOP_INSTR;
      assign w_skid_data       = '0;
      assign bus.in_ready      = bus.out_ready || !w_out_valid;
    end
  endgenerate

  assign bus.out_valid = w_out_valid;
  assign bus.occupancy = occ_of(w_out_valid, w_skid_valid);

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: one SKID=1/DW=32 instance and one SKID=0/DW=8
// instance. Monitors record accepted entries into per-instance queues and
// compare every emitted entry against the queue head; directed checks
// cover reset, occupancy, in_ready and bubble contents.
module tb_pipe_stage_reg;
  import pipe_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush1;
  logic flush0;

  int n_cmp = 0;
  int n_err = 0;

  logic [95:0] q1[$];
  logic [95:0] q0[$];

  pipe_stage_reg_if #(.DW(32)) if1 ();
  pipe_stage_reg_if #(.DW(8))  if0 ();

  pipe_stage_reg #(.DW(32), .RESET_PC(32'h0000_3000), .SKID(1'b1)) u_dut_s1 (
    .clk   (clk),
    .reset (reset),
    .flush (flush1),
    .bus   (if1)
  );

  pipe_stage_reg #(.DW(8), .RESET_PC(32'h0000_3000), .SKID(1'b0)) u_dut_s0 (
    .clk   (clk),
    .reset (reset),
    .flush (flush0),
    .bus   (if0)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {16'h2408, pc[15:0]};
  endfunction

  task automatic send1(input logic [31:0] pc);
    if1.in_valid = 1'b1;
    if1.in_pc    = pc;
    if1.in_instr = instr_of(pc);
    if1.in_data  = ~pc;
  endtask

  task automatic send0(input logic [31:0] pc, input logic [7:0] d);
    if0.in_valid = 1'b1;
    if0.in_pc    = pc;
    if0.in_instr = instr_of(pc);
    if0.in_data  = d;
  endtask

  // Scoreboard monitors: pop on emit, push on accept, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset || flush1) begin
      q1.delete();
    end else begin
      if (if1.out_valid && if1.out_ready) begin
        if (q1.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL s1_emit: got pc %0h required no entry", if1.out_pc);
        end else begin
          check("s1_emit", {if1.out_pc, if1.out_instr, if1.out_data}, q1.pop_front());
        end
      end
      if (if1.in_valid && if1.in_ready)
        q1.push_back({if1.in_pc, if1.in_instr, if1.in_data});
    end
  end

  always @(negedge clk) begin
    if (reset || flush0) begin
      q0.delete();
    end else begin
      if (if0.out_valid && if0.out_ready) begin
        if (q0.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL s0_emit: got pc %0h required no entry", if0.out_pc);
        end else begin
          check("s0_emit", {if0.out_pc, if0.out_instr, 24'h0, if0.out_data}, q0.pop_front());
        end
      end
      if (if0.in_valid && if0.in_ready)
        q0.push_back({if0.in_pc, if0.in_instr, 24'h0, if0.in_data});
    end
  end

  initial begin
    reset = 1'b1;
    flush1 = 1'b0;
    flush0 = 1'b0;
    if1.out_ready = 1'b1;
    if0.out_ready = 1'b1;
    if0.in_valid = 1'b0;
    if0.in_pc = '0;
    if0.in_instr = '0;
    if0.in_data = '0;
    send1(32'h3004);

    // 1. Reset held two cycles with a valid input present.
    tick();
    tick();
    check("rst_out_valid", if1.out_valid, 0);
    check("rst_out_pc",    if1.out_pc, 32'h3000);
    check("rst_out_instr", if1.out_instr, 0);
    check("rst_out_data",  if1.out_data, 0);
    check("rst_occ",       if1.occupancy, OCC_EMPTY);
    reset = 1'b0;
    if1.in_valid = 1'b0;
    tick();
    check("rst_in_ready",  if1.in_ready, 1);
    check("rst_out_valid2", if1.out_valid, 0);

    // 2. Streaming with out_ready=1.
    for (int i = 0; i < 4; i++) begin
      send1(32'h3000 + 32'(4 * i));
      check("stream_in_ready", if1.in_ready, 1);
      tick();
      check("stream_out_pc", if1.out_pc, 32'h3000 + 32'(4 * i));
      check("stream_occ", if1.occupancy, OCC_ONE);
    end
    if1.in_valid = 1'b0;
    if1.in_pc = 32'hDEAD_BEEF;
    if1.in_instr = 32'hFFFF_FFFF;
    if1.in_data = 32'h1234_5678;
    tick();
    check("bubble_valid", if1.out_valid, 0);
    check("bubble_instr", if1.out_instr, 0);
    check("bubble_data",  if1.out_data, 0);
    tick();
    check("bubble_pc_kept", if1.out_pc, 32'h300C);
    check("bubble_occ", if1.occupancy, OCC_EMPTY);

    // 3. Backpressure fills the skid slot.
    if1.out_ready = 1'b0;
    send1(32'h3000);
    tick();
    send1(32'h3004);
    tick();
    if1.in_valid = 1'b0;
    check("bp_out_pc", if1.out_pc, 32'h3000);
    check("bp_occ", if1.occupancy, OCC_TWO);
    check("bp_in_ready", if1.in_ready, 0);
    tick();
    check("bp_hold_pc", if1.out_pc, 32'h3000);
    if1.out_ready = 1'b1;
    tick();
    check("bp_drain_pc", if1.out_pc, 32'h3004);
    check("bp_drain_occ", if1.occupancy, OCC_ONE);
    check("bp_in_ready_back", if1.in_ready, 1);
    tick();
    check("bp_empty_occ", if1.occupancy, OCC_EMPTY);

    // 4. Flush with the stage full, input pending.
    if1.out_ready = 1'b0;
    send1(32'h3010);
    tick();
    send1(32'h3014);
    tick();
    check("fl_pre_occ", if1.occupancy, OCC_TWO);
    send1(32'h3018);
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    if1.in_valid = 1'b0;
    check("fl_out_valid", if1.out_valid, 0);
    check("fl_out_instr", if1.out_instr, 0);
    check("fl_out_data",  if1.out_data, 0);
    check("fl_out_pc",    if1.out_pc, 32'h3010);
    check("fl_occ",       if1.occupancy, OCC_EMPTY);
    check("fl_in_ready",  if1.in_ready, 1);
    if1.out_ready = 1'b1;
    tick();
    tick();
    check("fl_stays_empty", if1.out_valid, 0);

    // Flush from ONE while an input would have been accepted.
    if1.out_ready = 1'b0;
    send1(32'h3020);
    tick();
    send1(32'h3024);
    flush1 = 1'b1;
    tick();
    flush1 = 1'b0;
    if1.in_valid = 1'b0;
    check("fl1_out_valid", if1.out_valid, 0);
    check("fl1_out_pc", if1.out_pc, 32'h3020);
    check("fl1_occ", if1.occupancy, OCC_EMPTY);
    if1.out_ready = 1'b1;
    tick();
    check("fl1_dropped", if1.out_valid, 0);

    // 5. SKID=0 instance, out_ready 1,0,1.
    send0(32'h3200, 8'hA1);
    #1;
    check("s0_rdy_empty", if0.in_ready, 1);
    tick();
    check("s0_a1", if0.out_data, 8'hA1);
    check("s0_a1_valid", if0.out_valid, 1);
    if0.out_ready = 1'b0;
    send0(32'h3204, 8'hA2);
    #1;
    check("s0_rdy_low", if0.in_ready, 0);
    tick();
    check("s0_a1_held", if0.out_data, 8'hA1);
    if0.out_ready = 1'b1;
    #1;
    check("s0_rdy_high", if0.in_ready, 1);
    tick();
    check("s0_a2", if0.out_data, 8'hA2);
    send0(32'h3208, 8'hA3);
    tick();
    check("s0_a3", if0.out_data, 8'hA3);
    check("s0_a3_pc", if0.out_pc, 32'h3208);
    if0.in_valid = 1'b0;
    tick();
    check("s0_drained", if0.out_valid, 0);

    // 6. Reset in the middle of a stall.
    if1.out_ready = 1'b0;
    send1(32'h3030);
    tick();
    send1(32'h3034);
    tick();
    if1.in_valid = 1'b0;
    check("mr_pre_occ", if1.occupancy, OCC_TWO);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_out_valid", if1.out_valid, 0);
    check("mr_out_pc", if1.out_pc, 32'h3000);
    check("mr_out_instr", if1.out_instr, 0);
    check("mr_out_data", if1.out_data, 0);
    check("mr_occ", if1.occupancy, OCC_EMPTY);
    check("mr_in_ready", if1.in_ready, 1);
    if1.out_ready = 1'b1;
    send1(32'h3100);
    tick();
    if1.in_valid = 1'b0;
    check("mr_next_valid", if1.out_valid, 1);
    check("mr_next_pc", if1.out_pc, 32'h3100);
    tick();
    check("mr_end_occ", if1.occupancy, OCC_EMPTY);

    tick();
    check("s1_queue_drained", 96'(q1.size()), 0);
    check("s0_queue_drained", 96'(q0.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
